tx_gate_ctrl_list: RTL and testbench

//   Time-aware gate control list (GCL) sequencer for one TX port. Holds a programmable table of
//   {gate-state, interval} entries and replays it cyclically, driving the per-priority gate vector
//   (o_ControlList_state) consumed by tx_qos_mng. Sits between the register block / PTP cycle-start

---
 rtl/tx_gate_ctrl_list.sv | 195 +++++++++++++++++++
 tb/tb_tx_gate_ctrl_list.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gate_ctrl_list.sv
// -----------------------------------------------------------------------------
// tx_gate_ctrl_list
//   Time-aware gate control list sequencer for one TX port. A table of
//   {gate vector, interval} entries is replayed cyclically. Each entry drives
//   o_ControlList_state for max(interval,1) clock cycles. When the list is not
//   running, the admin gate state is passed through with one cycle of latency.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous reset, active-high
//   i_gcl_wr_en         table write strobe
//   i_gcl_wr_addr       table write index
//   i_gcl_wr_gate       gate vector for the written entry (1 = open)
//   i_gcl_wr_interval   duration of the written entry, in cycles
//   i_gcl_len           number of active entries, legal 1..GCL_DEPTH
//   i_admin_gate_state  gate vector applied while not running
//   i_gate_enable       level: list operation enabled
//   i_cycle_start       one-cycle pulse: (re)start the list at entry 0
//   o_ControlList_state registered gate vector
//   o_gate_update       pulse: o_ControlList_state reloaded this cycle
//   o_gcl_index         entry currently applied
//   o_cycle_done        pulse: last entry expired and the list wrapped to 0
//   o_gate_running      1 while the list is running (FSM state)
//   o_cfg_err           sticky until the next accepted start: illegal length
// -----------------------------------------------------------------------------
module tx_gate_ctrl_list #(
   parameter int PORT_FIFO_PRI_NUM = 8,
   parameter int GCL_DEPTH         = 16,
   parameter int GCL_ADDR_W        = 4,
   parameter int INTERVAL_W        = 24
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_gcl_wr_en,
   input  logic [GCL_ADDR_W-1:0]        i_gcl_wr_addr,
   input  logic [PORT_FIFO_PRI_NUM-1:0] i_gcl_wr_gate,
   input  logic [INTERVAL_W-1:0]        i_gcl_wr_interval,
   input  logic [GCL_ADDR_W:0]          i_gcl_len,
   input  logic [PORT_FIFO_PRI_NUM-1:0] i_admin_gate_state,
   input  logic                         i_gate_enable,
   input  logic                         i_cycle_start,
   output logic [PORT_FIFO_PRI_NUM-1:0] o_ControlList_state,
   output logic                         o_gate_update,
   output logic [GCL_ADDR_W-1:0]        o_gcl_index,
   output logic                         o_cycle_done,
   output logic                         o_gate_running,
   output logic                         o_cfg_err
);

   localparam logic [GCL_ADDR_W:0]   LP_DEPTH = (GCL_ADDR_W+1)'(GCL_DEPTH);
   localparam logic [GCL_ADDR_W-1:0] LP_LAST  = GCL_ADDR_W'(GCL_DEPTH-1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                         r_state;
   logic [PORT_FIFO_PRI_NUM-1:0]   r_tbl_gate [GCL_DEPTH];
   logic [INTERVAL_W-1:0]          r_tbl_int  [GCL_DEPTH];
   logic [INTERVAL_W-1:0]          r_cnt;
   logic [GCL_ADDR_W-1:0]          r_index;
   logic [PORT_FIFO_PRI_NUM-1:0]   r_ctl_state;
   logic                           r_gate_update;
   logic                           r_cycle_done;
   logic                           r_running;
   logic                           r_cfg_err;

   logic                           w_len_ok;
   logic                           w_wrap;
   logic [GCL_ADDR_W-1:0]          w_next_idx;
   logic [INTERVAL_W-1:0]          w_cnt_first;
   logic [INTERVAL_W-1:0]          w_cnt_next;
   logic                           w_admin_chg;

   // Counter load value: an interval of 0 behaves like 1, so every entry
   // lasts max(interval,1) cycles (counter runs from load value down to 0).
   function automatic logic [INTERVAL_W-1:0] f_cnt_load(input logic [INTERVAL_W-1:0] iv);
      return (iv == '0) ? '0 : iv - INTERVAL_W'(1);
   endfunction

   // -------------------------------------------------------------------------
   // Gate control table. Registered, so a write lands on the edge after the
   // strobe; a load from the same entry on that edge sees the old contents.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < GCL_DEPTH; i++) begin
            r_tbl_gate[i] <= '1;
            r_tbl_int[i]  <= '0;
         end
      end else if (i_gcl_wr_en && ({1'b0, i_gcl_wr_addr} < LP_DEPTH)) begin
         r_tbl_gate[i_gcl_wr_addr] <= i_gcl_wr_gate;
         r_tbl_int[i_gcl_wr_addr]  <= i_gcl_wr_interval;
      end
   end

   // -------------------------------------------------------------------------
   // Next-entry selection. The length is sampled at every advance; using
   // index+1 >= len (rather than index == len-1) makes a list that shrank
   // below the current index wrap at the next expiry instead of running off.
   // -------------------------------------------------------------------------
   always_comb begin
      w_len_ok    = (i_gcl_len != '0) && (i_gcl_len <= LP_DEPTH);
      w_wrap      = (({1'b0, r_index} + (GCL_ADDR_W+1)'(1)) >= i_gcl_len) ||
                    (r_index == LP_LAST);
      w_next_idx  = w_wrap ? '0 : r_index + GCL_ADDR_W'(1);
      w_cnt_first = f_cnt_load(r_tbl_int[0]);
      w_cnt_next  = f_cnt_load(r_tbl_int[w_next_idx]);
      w_admin_chg = (i_admin_gate_state != r_ctl_state);
   end

   // -------------------------------------------------------------------------
   // Sequencer FSM with registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_index       <= '0;
         r_ctl_state   <= '0;
         r_gate_update <= 1'b0;
         r_cycle_done  <= 1'b0;
         r_running     <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_gate_update <= 1'b0;
         r_cycle_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_gate_enable && i_cycle_start && w_len_ok) begin
                  r_state       <= ST_RUN;
                  r_running     <= 1'b1;
                  r_cfg_err     <= 1'b0;
                  r_index       <= '0;
                  r_ctl_state   <= r_tbl_gate[0];
                  r_cnt         <= w_cnt_first;
                  r_gate_update <= 1'b1;
               end else begin
                  if (i_gate_enable && i_cycle_start) begin
                     r_cfg_err <= 1'b1;
                  end
                  r_running     <= 1'b0;
                  r_index       <= '0;
                  r_cnt         <= '0;
                  r_ctl_state   <= i_admin_gate_state;
                  r_gate_update <= w_admin_chg;
               end
            end

            ST_RUN: begin
               if (!i_gate_enable || (i_cycle_start && !w_len_ok)) begin
                  // Leave RUN; admin state is applied on this same edge.
                  if (i_gate_enable) begin
                     r_cfg_err <= 1'b1;
                  end
                  r_state       <= ST_IDLE;
                  r_running     <= 1'b0;
                  r_index       <= '0;
                  r_cnt         <= '0;
                  r_ctl_state   <= i_admin_gate_state;
                  r_gate_update <= w_admin_chg;
               end else if (i_cycle_start) begin
                  // Restart takes precedence over expiry; no cycle_done.
                  r_cfg_err     <= 1'b0;
                  r_index       <= '0;
                  r_ctl_state   <= r_tbl_gate[0];
                  r_cnt         <= w_cnt_first;
                  r_gate_update <= 1'b1;
               end else if (r_cnt == '0) begin
                  r_index       <= w_next_idx;
                  r_ctl_state   <= r_tbl_gate[w_next_idx];
                  r_cnt         <= w_cnt_next;
                  r_gate_update <= 1'b1;
                  r_cycle_done  <= w_wrap;
               end else begin
                  r_cnt <= r_cnt - INTERVAL_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ControlList_state = r_ctl_state;
   assign o_gate_update       = r_gate_update;
   assign o_gcl_index         = r_index;
   assign o_cycle_done        = r_cycle_done;
   assign o_gate_running      = r_running;
   assign o_cfg_err           = r_cfg_err;

endmodule

// File: tb/tb_tx_gate_ctrl_list.sv
// -----------------------------------------------------------------------------
// tb_tx_gate_ctrl_list
//   Directed bench for tx_gate_ctrl_list. Stimulus pushes the expected gate
//   reloads ({cycles since previous reload, cycle_done, index, gate}) into
//   exp_q; a monitor pops one entry for every o_gate_update pulse. A cycle
//   gap of 0 in an expected entry means the spacing is not checked.
// -----------------------------------------------------------------------------
module tb_tx_gate_ctrl_list;

   localparam int P  = 8;
   localparam int D  = 16;
   localparam int AW = 4;
   localparam int IW = 24;
   localparam int EW = 21;  // {gap[7:0], done, idx[3:0], gate[7:0]}

   logic          clk;
   logic          rst;
   logic          gcl_wr_en;
   logic [AW-1:0] gcl_wr_addr;
   logic [P-1:0]  gcl_wr_gate;
   logic [IW-1:0] gcl_wr_interval;
   logic [AW:0]   gcl_len;
   logic [P-1:0]  admin_gate_state;
   logic          gate_enable;
   logic          cycle_start;
   logic [P-1:0]  ctl_state;
   logic          gate_update;
   logic [AW-1:0] gcl_index;
   logic          cycle_done;
   logic          gate_running;
   logic          cfg_err;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            gap      = 0;

   tx_gate_ctrl_list #(
      .PORT_FIFO_PRI_NUM(P),
      .GCL_DEPTH(D),
      .GCL_ADDR_W(AW),
      .INTERVAL_W(IW)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_gcl_wr_en        (gcl_wr_en),
      .i_gcl_wr_addr      (gcl_wr_addr),
      .i_gcl_wr_gate      (gcl_wr_gate),
      .i_gcl_wr_interval  (gcl_wr_interval),
      .i_gcl_len          (gcl_len),
      .i_admin_gate_state (admin_gate_state),
      .i_gate_enable      (gate_enable),
      .i_cycle_start      (cycle_start),
      .o_ControlList_state(ctl_state),
      .o_gate_update      (gate_update),
      .o_gcl_index        (gcl_index),
      .o_cycle_done       (cycle_done),
      .o_gate_running     (gate_running),
      .o_cfg_err          (cfg_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [EW-1:0] mk(input logic [7:0] g, input logic d,
                                        input logic [3:0] idx, input logic [7:0] gate);
      return {g, d, idx, gate};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [P-1:0] g, input logic [IW-1:0] iv);
      gcl_wr_en       = 1'b1;
      gcl_wr_addr     = a;
      gcl_wr_gate     = g;
      gcl_wr_interval = iv;
      tick();
      gcl_wr_en       = 1'b0;
   endtask

   task automatic pulse_start();
      cycle_start = 1'b1;
      tick();
      cycle_start = 1'b0;
   endtask

   // Wait (bounded) until every expected reload has been seen.
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      int            eg;
      if (rst) begin
         gap = 0;
      end else begin
         gap = gap + 1;
         if (gate_update) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_update: gate=%h idx=%0d done=%0b", ctl_state, gcl_index, cycle_done);
            end else begin
               e  = exp_q.pop_front();
               eg = int'(e[20:13]);
               if ((eg == 0 || eg == gap) && cycle_done == e[12] &&
                   gcl_index == e[11:8] && ctl_state == e[7:0]) begin
                  n_pass++;
               end else begin
                  $display("FAIL reload: got gap=%0d done=%0b idx=%0d gate=%h expected gap=%0d done=%0b idx=%0d gate=%h",
                           gap, cycle_done, gcl_index, ctl_state, eg, e[12], e[11:8], e[7:0]);
               end
            end
            gap = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst              = 1'b1;
      gcl_wr_en        = 1'b0;
      gcl_wr_addr      = '0;
      gcl_wr_gate      = '0;
      gcl_wr_interval  = '0;
      gcl_len          = '0;
      admin_gate_state = 8'hFF;
      gate_enable      = 1'b0;
      cycle_start      = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_state",   ctl_state,    0);
      chk("rst_update",  gate_update,  0);
      chk("rst_index",   gcl_index,    0);
      chk("rst_done",    cycle_done,   0);
      chk("rst_running", gate_running, 0);
      chk("rst_cfg_err", cfg_err,      0);

      // Leaving reset: admin 0xFF replaces reset value 0 -> one update
      exp_q.push_back(mk(0, 0, 0, 8'hFF));
      rst = 1'b0;
      wr(0, 8'h01, 4);
      wr(1, 8'h02, 2);
      wr(2, 8'hFC, 1);
      gcl_len = 3;
      drain("drain_admin");

      // Test 1: len=3 list, two full passes
      exp_q.push_back(mk(0, 0, 0, 8'h01));
      exp_q.push_back(mk(4, 0, 1, 8'h02));
      exp_q.push_back(mk(2, 0, 2, 8'hFC));
      exp_q.push_back(mk(1, 1, 0, 8'h01));
      exp_q.push_back(mk(4, 0, 1, 8'h02));
      exp_q.push_back(mk(2, 0, 2, 8'hFC));
      exp_q.push_back(mk(1, 1, 0, 8'h01));
      gate_enable = 1'b1;
      pulse_start();
      chk("run_running", gate_running, 1);
      chk("run_index0",  gcl_index,    0);
      drain("drain_t1");

      // Test 3: restart in the middle of entry 1
      exp_q.push_back(mk(4, 0, 1, 8'h02));
      exp_q.push_back(mk(1, 0, 0, 8'h01));
      exp_q.push_back(mk(4, 0, 1, 8'h02));
      exp_q.push_back(mk(2, 0, 2, 8'hFC));
      exp_q.push_back(mk(1, 1, 0, 8'h01));
      n = 0;
      while (gcl_index != 1 && n < 50) begin
         tick();
         n++;
      end
      chk("wait_entry1", gcl_index, 1);
      pulse_start();
      chk("restart_index", gcl_index,  0);
      chk("restart_gate",  ctl_state,  8'h01);
      chk("restart_done",  cycle_done, 0);
      drain("drain_t3");

      // Test 5a: drop enable in RUN
      exp_q.push_back(mk(0, 0, 0, 8'hFF));
      gate_enable = 1'b0;
      tick();
      chk("dis_running", gate_running, 0);
      chk("dis_state",   ctl_state,    8'hFF);
      chk("dis_index",   gcl_index,    0);
      drain("drain_t5a");

      // Test 4: illegal length 0
      gcl_len     = 0;
      gate_enable = 1'b1;
      pulse_start();
      chk("len0_cfg_err", cfg_err,      1);
      chk("len0_running", gate_running, 0);
      chk("len0_state",   ctl_state,    8'hFF);
      tick();
      tick();
      chk("len0_sticky",  cfg_err,      1);
      chk("len0_idle",    gate_running, 0);

      // Tests 2 and 6: len=2; then rewrite entry 1 to {0x0F, 0} during entry 0
      gcl_len = 2;
      exp_q.push_back(mk(0, 0, 0, 8'h01));
      exp_q.push_back(mk(4, 0, 1, 8'h02));
      exp_q.push_back(mk(2, 1, 0, 8'h01));
      pulse_start();
      chk("len2_cfg_clr", cfg_err,      0);
      chk("len2_running", gate_running, 1);
      drain("drain_len2");
      exp_q.push_back(mk(4, 0, 1, 8'h0F));
      exp_q.push_back(mk(1, 1, 0, 8'h01));
      exp_q.push_back(mk(4, 0, 1, 8'h0F));
      exp_q.push_back(mk(1, 1, 0, 8'h01));
      wr(1, 8'h0F, 0);
      drain("drain_t2_t6");

      // len reduced to 1 while running: entry 0 reloads every 4 cycles
      gcl_len = 1;
      exp_q.push_back(mk(4, 1, 0, 8'h01));
      exp_q.push_back(mk(4, 1, 0, 8'h01));
      drain("drain_len1");

      // Test 5b: reset in RUN
      rst = 1'b1;
      tick();
      chk("rst2_state",   ctl_state,    0);
      chk("rst2_running", gate_running, 0);
      chk("rst2_index",   gcl_index,    0);
      chk("rst2_update",  gate_update,  0);
      chk("rst2_done",    cycle_done,   0);
      chk("rst2_cfg_err", cfg_err,      0);
      tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
